// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared types and constants for the BCD timer sequencer.
// Holds the run-state enum, the BCD digit width and the max digit value.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  localparam int          DIG_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Command/status bundle between the board controller and the timer.
// master drives commands and load_val; slave drives bcd and status.
interface bcd_timer_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                start;
  logic                stop;
  logic                clear;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic                dir;
  logic [4*DIGITS-1:0] bcd;
  logic                running;
  logic                done;
  logic                at_limit;

  modport master (
    output start, stop, clear, load, load_val, dir,
    input  bcd, running, done, at_limit
  );

  modport slave (
    input  start, stop, clear, load, load_val, dir,
    output bcd, running, done, at_limit
  );

endinterface

// File: rtl/bcd_timer_ctrl_digit.sv
// One BCD digit with synchronous load and up/down step.
// Ports: clk, rst_n, ld_i/ld_val_i, en_i, up_i in; q_o, co_o out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic [DIG_W-1:0] ld_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [DIG_W-1:0] q_o,
  output logic             co_o
);

  logic [DIG_W-1:0] q_q, q_d;

  // Carry (up) or borrow (down) fires when this digit wraps.
  assign co_o = en_i & (up_i ? (q_q == BCD_MAX) : (q_q == '0));
  assign q_o  = q_q;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (en_i) begin
      if (up_i) q_d = (q_q == BCD_MAX) ? '0 : q_q + 1'b1;
      else      q_d = (q_q == '0) ? BCD_MAX : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Start/stop/pause up-down BCD timer: FSM, prescaler, digit chain.
// Ports: clk, rst_n, bus (slave: commands in, bcd/status out).
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000
)(
  input logic             clk,
  input logic             rst_n,
  bcd_timer_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            dir_q, dir_d;
  logic            done_q;

  logic                ld;
  logic [4*DIGITS-1:0] ld_val;
  logic [4*DIGITS-1:0] clamped;
  logic                step;
  logic [DIGITS-1:0]   en, co;
  logic [DIG_W-1:0]    q [DIGITS];

  logic lim_up, lim_dn, pre_up, pre_dn;

  always_comb begin
    clamped = '0;
    lim_up  = 1'b1;
    lim_dn  = 1'b1;
    pre_up  = (q[0] == 4'd8);
    pre_dn  = (q[0] == 4'd1);
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (bus.load_val[4*i +: 4] > BCD_MAX)
                          ? BCD_MAX : bus.load_val[4*i +: 4];
      lim_up = lim_up & (q[i] == BCD_MAX);
      lim_dn = lim_dn & (q[i] == '0);
      if (i > 0) begin
        pre_up = pre_up & (q[i] == BCD_MAX);
        pre_dn = pre_dn & (q[i] == '0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    ld      = 1'b0;
    ld_val  = '0;
    step    = 1'b0;
    if (bus.clear) begin
      ld      = 1'b1;
      presc_d = '0;
      state_d = IDLE;
    end else if (bus.load) begin
      ld      = 1'b1;
      ld_val  = clamped;
      presc_d = '0;
      state_d = IDLE;
    end else if (bus.stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (bus.start) begin
            dir_d   = bus.dir;
            state_d = (bus.dir ? lim_up : lim_dn) ? DONE : RUN;
          end
        end
        RUN: begin
          if (presc_q == PMAX) begin
            presc_d = '0;
            step    = 1'b1;
            // Last step lands exactly on the limit.
            if (dir_q ? pre_up : pre_dn) state_d = DONE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      done_q  <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign en[0] = step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i > 0) begin : g_chain
      assign en[i] = co[i-1];
    end
    bcd_digit u_dig (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_i     (ld),
      .ld_val_i (ld_val[4*i +: 4]),
      .en_i     (en[i]),
      .up_i     (dir_q),
      .q_o      (q[i]),
      .co_o     (co[i])
    );
    assign bus.bcd[4*i +: 4] = q[i];
  end

  assign bus.running  = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.at_limit = dir_q ? lim_up : lim_dn;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl with an integer timer model.
// Directed command sequences plus per-cycle output comparison.
module tb_bcd_timer_ctrl;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_timer_ctrl #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: timer value as a plain integer, states as small ints.
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  localparam int MAXV = 9999;

  int m_val   = 0;
  int m_presc = 0;
  int m_st    = S_IDLE;
  bit m_dir   = 1'b0;
  bit m_done  = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int r, w;
    logic [3:0] n;
    r = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      n = lv[4*i +: 4];
      r = r + ((n > 4'd9) ? 9 : int'(n)) * w;
      w = w * 10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_presc = 0; m_st = S_IDLE; m_dir = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (bus.clear) begin
        m_val = 0; m_presc = 0; m_st = S_IDLE;
      end else if (bus.load) begin
        m_val = from_load(bus.load_val); m_presc = 0; m_st = S_IDLE;
      end else if (bus.stop) begin
        if (m_st == S_RUN) m_st = S_PAUSE;
      end else if (bus.start && (m_st == S_IDLE || m_st == S_PAUSE)) begin
        m_dir = bus.dir;
        if (m_val == (m_dir ? MAXV : 0)) begin
          m_st = S_DONE; m_done = 1;
        end else begin
          m_st = S_RUN;
        end
      end else if (m_st == S_RUN) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_val = m_dir ? m_val + 1 : m_val - 1;
          if (m_val == (m_dir ? MAXV : 0)) begin
            m_st = S_DONE; m_done = 1;
          end
        end else begin
          m_presc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("bcd", 32'(bus.bcd), 32'(to_bcd(m_val)));
      check("running", 32'(bus.running), 32'(m_st == S_RUN));
      check("done", 32'(bus.done), 32'(m_done));
      check("at_limit", 32'(bus.at_limit),
            32'(m_val == (m_dir ? MAXV : 0)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
    bus.load_val = '0; bus.dir = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1);
    check("rst_bcd", 32'(bus.bcd), 32'h0000);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    // Count up 11 steps.
    bus.dir = 1; bus.start = 1; cyc(1); bus.start = 0;
    check("run_rise", 32'(bus.running), 32'd1);
    cyc(43);
    check("up_43", 32'(bus.bcd), 32'h0010);
    cyc(1);
    check("up_44", 32'(bus.bcd), 32'h0011);
    check("up_running", 32'(bus.running), 32'd1);

    // Two-digit carry.
    bus.load = 1; bus.load_val = 16'h0099; cyc(1); bus.load = 0;
    bus.start = 1; cyc(1); bus.start = 0;
    cyc(4);
    check("carry", 32'(bus.bcd), 32'h0100);

    // Count down into DONE.
    bus.load = 1; bus.load_val = 16'h0001; cyc(1); bus.load = 0;
    bus.dir = 0; bus.start = 1; cyc(1); bus.start = 0;
    cyc(4);
    check("dn_bcd", 32'(bus.bcd), 32'h0000);
    check("dn_done", 32'(bus.done), 32'd1);
    check("dn_running", 32'(bus.running), 32'd0);
    check("dn_limit", 32'(bus.at_limit), 32'd1);
    cyc(1);
    check("done_pulse", 32'(bus.done), 32'd0);
    bus.start = 1; cyc(2); bus.start = 0;
    check("done_sticky", 32'(bus.running), 32'd0);

    // Pause preserves prescaler.
    bus.clear = 1; cyc(1); bus.clear = 0;
    bus.dir = 1; bus.start = 1; cyc(1); bus.start = 0;
    cyc(2);
    bus.stop = 1; cyc(10); bus.stop = 0;
    check("pause_bcd", 32'(bus.bcd), 32'h0000);
    check("pause_run", 32'(bus.running), 32'd0);
    bus.start = 1; cyc(1); bus.start = 0;
    cyc(1);
    check("resume_wait", 32'(bus.bcd), 32'h0000);
    cyc(1);
    check("resume_step", 32'(bus.bcd), 32'h0001);

    // Load clamp, then clear beats start.
    bus.load = 1; bus.load_val = 16'hF3A9; cyc(1); bus.load = 0;
    check("clamp", 32'(bus.bcd), 32'h9399);
    bus.clear = 1; bus.start = 1; cyc(1); bus.clear = 0; bus.start = 0;
    check("clr_bcd", 32'(bus.bcd), 32'h0000);
    check("clr_run", 32'(bus.running), 32'd0);

    // Borrow across a digit.
    bus.load = 1; bus.load_val = 16'h0010; cyc(1); bus.load = 0;
    bus.dir = 0; bus.start = 1; cyc(1); bus.start = 0;
    cyc(4);
    check("borrow", 32'(bus.bcd), 32'h0009);

    // Async reset mid-run.
    bus.load = 1; bus.load_val = 16'h0057; cyc(1); bus.load = 0;
    bus.dir = 1; bus.start = 1; cyc(1); bus.start = 0;
    cyc(1);
    check("pre_rst", 32'(bus.bcd), 32'h0057);
    #1 rst_n = 1'b0;
    #1;
    check("arst_bcd", 32'(bus.bcd), 32'h0000);
    check("arst_run", 32'(bus.running), 32'd0);
    #3 rst_n = 1'b1;
    cyc(2);
    check("post_rst", 32'(bus.bcd), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Sequencer for a chain of decimal digit counters forming a start/stop/pause up- or down-timer for the lab board's seven-segment display path. It owns the prescaler, the run/pause/done state machine, digit-to-digit carry/borrow chaining, terminal-count detection and parallel preset. Its BCD outputs feed the display multiplexer directly.

## Interface
- DIGITS, 4, number of BCD digits; digit 0 is least significant.
- TICK_DIV, 100000, clk cycles per count step; minimum 2.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begin or resume counting.
- stop  in  1  level; pause counting.
- clear  in  1  level; zero all digits and return to IDLE.
- load  in  1  level; preset digits from load_val and return to IDLE.
- load_val  in  4*DIGITS  BCD preset, nibble i = digit i.
- dir  in  1  1 = count up, 0 = count down; latched on IDLE/PAUSE -> RUN.
- bcd  out  4*DIGITS  current digit values.
- running  out  1  high while state is RUN.
- done  out  1  one-cycle pulse on entry to DONE.
- at_limit  out  1  combinational: bcd is all 9s when dir_q = 1, all 0s when dir_q = 0.

## Operation
- Reset: bcd = 0, state IDLE, prescaler 0, dir_q = 0, running = 0, done = 0.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority each cycle: clear > load > stop > start.
- clear: in any state, bcd <= 0, prescaler <= 0, next state IDLE.
- load: in any state, each nibble > 9 is clamped to 9 and written, prescaler <= 0, next state IDLE.
- IDLE/PAUSE + start + no stop: dir_q <= dir, next state RUN. If bcd already equals the limit for dir, go directly to DONE and pulse done.
- RUN + stop: next state PAUSE; prescaler holds its value; no step that cycle.
- RUN, prescaler == TICK_DIV-1: prescaler <= 0 and a step is issued. Otherwise prescaler increments.
- Step up: digit 0 increments. A digit at 9 wraps to 0 and carries into the next digit, rippling in one cycle.
- Step down: digit 0 decrements. A digit at 0 wraps to 9 and borrows from the next digit.
- If the post-step value equals the limit (all 9s up, all 0s down), next state is DONE and done pulses. No wrap past the limit ever occurs.
- DONE: bcd holds; start is ignored; only clear or load leaves DONE.
- PAUSE + start: resume with prescaler continuing from its held value. dir is re-latched.
- dir changes while in RUN are ignored.

## Timing
- A command sampled at edge n takes effect at edge n; outputs reflect it after edge n.
- First step occurs TICK_DIV cycles after the edge that enters RUN from IDLE.
- running rises and falls with the state register; no extra latency.
- done is high for exactly the cycle after the DONE-entry edge.
- A prescaler rollover and stop in the same cycle: stop wins and the step is dropped.
- Deasserting rst_n mid-count forces reset values immediately. Release is synchronous to clk.
- Carry and borrow ripple across all DIGITS combinationally. Steps are single-cycle.

## Structure
- Shared package bcd_pkg holds the state enum (IDLE, RUN, PAUSE, DONE), the BCD_MAX = 4'd9 constant and the digit width constant.
- Sub-module bcd_digit: one 4-bit digit with async active-low reset, synchronous load, and en/up inputs. It provides a combinational carry/borrow output and is instantiated DIGITS times in a generate loop.
- Top-level logic contains the FSM, prescaler, load clamp and limit compare.

## Test plan
Bench parameters: TICK_DIV = 4, DIGITS = 4.
- Reset, then start with dir = 1 for 44 cycles: bcd goes 0000 -> 0011 with one step every 4 cycles; running = 1.
- load 0099, then start with dir = 1: after 4 cycles bcd = 0100 (two-digit carry in one step).
- load 0001, then start with dir = 0: after 4 cycles bcd = 0000, state DONE, done high for 1 cycle, running = 0. A later start leaves the state DONE.
- In RUN, assert stop for 10 cycles, then start: bcd frozen during the pause. The next step arrives after the remaining prescaler cycles, with total step spacing excluding the pause equal to 4.
- load F3A9: bcd = 9399 (clamped). clear and start in the same cycle: bcd = 0000, state IDLE.
- Drop rst_n mid-RUN at bcd = 0057: bcd = 0000, running = 0 immediately, before the next clk edge.
